// File: rtl/fifo_stream_out_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Widths default to those of the companion synchronous FIFO.
package fifo_stream_out_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  function automatic occ_t occ_next(
    input occ_t occ,
    input logic push,
    input logic pop
  );
    return occ + occ_t'(push) - occ_t'(pop);
  endfunction

endpackage

// File: rtl/fifo_stream_out_skid_buf2.sv
// Two-entry shift buffer: head in buf0, pop shifts buf1 forward,
// push lands in the first free slot after the pop is applied.
module skid_buf2
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output occ_t                  occ_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  occ_t                  occ_q, occ_d, occ_pop;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  always_comb begin
    occ_pop = occ_q - occ_t'(pop_i);
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    if (pop_i) begin
      buf0_d = buf1_q;
    end
    if (push_i) begin
      if (occ_pop == '0) buf0_d = push_data_i;
      else               buf1_d = push_data_i;
    end
    occ_d = occ_next(occ_q, push_i, pop_i);
    if (flush_i) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= '0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = buf0_q;

endmodule

// File: rtl/fifo_stream_out.sv
// FIFO read adapter: turns rd_en/empty/registered data_out into a
// valid/ready stream through a 2-entry skid buffer.
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  err_underflow
);

  occ_t                 occ;
  logic                 pop;
  logic                 push;
  logic                 inflight_q;
  logic [2:0]           need;
  logic [CNT_WIDTH-1:0] beat_cnt_q;
  logic                 err_q;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  // Data from a read issued just before a flush is dropped.
  assign push    = inflight_q && !flush;
  assign need    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};

  assign fifo_rd_en = rst_n && !flush && !fifo_empty
                   && (need < 3'(SKID_DEPTH));

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (m_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (pop) begin
        beat_cnt_q <= beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (fifo_underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  assign beat_cnt      = beat_cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural
// one-cycle-latency FIFO model driven from the stimulus thread.
module tb_fifo_stream_out;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        flush;
  logic [15:0] beat_cnt;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [15:0] fq[$];
  logic [15:0] got[$];

  always #5 clk = ~clk;

  fifo_stream_out dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .flush          (flush),
    .beat_cnt       (beat_cnt),
    .err_underflow  (err_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
    fifo_empty = (fq.size() == 0);
    #1;
  endtask

  // One clock: sample handshakes before the edge, then update the FIFO.
  task automatic step();
    logic rd_s;
    rd_s = fifo_rd_en;
    if (m_valid && m_ready) got.push_back(m_data);
    if (rd_s) rd_cnt++;
    @(posedge clk);
    #1;
    if (rd_s && fq.size() != 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    fifo_empty     = 1'b1;
    fifo_data      = 16'h0;
    fifo_underflow = 1'b0;
    m_ready        = 1'b1;
    flush          = 1'b0;
    push_words(16'h0001, 8);

    // reset with a non-empty FIFO
    step();
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);

    // streaming
    rst_n = 1'b1;
    #1;
    chk("st_rd0", 32'(fifo_rd_en), 32'd1);
    step();
    chk("st_valid_lat1", 32'(m_valid), 32'd0);
    step();
    got.delete();
    for (int i = 0; i < 8; i++) begin
      chk("st_valid", 32'(m_valid), 32'd1);
      chk("st_data", 32'(m_data), 32'(i + 1));
      step();
    end
    chk("st_nbeats", 32'(got.size()), 32'd8);
    chk("st_done_valid", 32'(m_valid), 32'd0);
    chk("st_cnt", 32'(beat_cnt), 32'd8);
    chk("st_rd_empty", 32'(fifo_rd_en), 32'd0);

    // backpressure
    push_words(16'hA000, 10);
    got.delete();
    step();
    step();
    m_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("bp_valid", 32'(m_valid), 32'd1);
      chk("bp_hold", 32'(m_data), 32'hA000);
      step();
      chk("bp_occ", 32'(dut.occ), 32'd2);
    end
    m_ready = 1'b1;
    #1;
    for (int n = 0; n < 40 && got.size() < 10; n++) step();
    chk("bp_nbeats", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk("bp_order", 32'(got[i]), 32'(16'hA000 + 16'(i)));
    chk("bp_cnt", 32'(beat_cnt), 32'd18);

    // single entry
    for (int i = 0; i < 3; i++) step();
    got.delete();
    rd_cnt = 0;
    push_words(16'h1234, 1);
    for (int i = 0; i < 10; i++) step();
    chk("se_rd_pulses", 32'(rd_cnt), 32'd1);
    chk("se_nbeats", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("se_data", 32'(got[0]), 32'h1234);
    chk("se_cnt", 32'(beat_cnt), 32'd19);

    // flush with one buffered word and one in flight
    got.delete();
    m_ready = 1'b0;
    push_words(16'hB000, 6);
    step();
    step();
    chk("fl_pre_occ", 32'(dut.occ), 32'd1);
    chk("fl_pre_infl", 32'(dut.inflight_q), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_rd_en", 32'(fifo_rd_en), 32'd0);
    step();
    flush   = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("fl_valid", 32'(m_valid), 32'd0);
    for (int n = 0; n < 40 && got.size() < 4; n++) step();
    chk("fl_nbeats", 32'(got.size()), 32'd4);
    if (got.size() > 0) chk("fl_next", 32'(got[0]), 32'hB002);
    if (got.size() > 3) chk("fl_last", 32'(got[3]), 32'hB005);
    chk("fl_cnt", 32'(beat_cnt), 32'd23);

    // sticky underflow flag
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    #1;
    chk("uf_set", 32'(err_underflow), 32'd1);
    for (int i = 0; i < 4; i++) step();
    chk("uf_sticky", 32'(err_underflow), 32'd1);

    // reset mid-stream drops buffered data at once
    push_words(16'hC000, 4);
    step();
    step();
    chk("mr_pre_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(m_valid), 32'd0);
    chk("mr_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mr_err", 32'(err_underflow), 32'd0);
    chk("mr_cnt", 32'(beat_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
